sipo_deser: RTL and testbench

SIPO_DESER -- requirements
Module: sipo_deser

---
 rtl/sipo_deser.sv | 152 +++++++++++++++
 tb/tb_sipo_deser.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// sipo_deser -- serial-in / parallel-out deserializer with a one-word holding
// register and a ready/valid handshake on the parallel side.
//
// Parameters
//   WIDTH      : parallel word width (2..32)
//   LSB_FIRST  : 0 = first received bit ends up in po[WIDTH-1],
//                1 = first received bit ends up in po[0]
//   PARITY_ODD : parity sense for the optional parity bit (0 = even, 1 = odd)
//
// Build option
//   SIPO_PARITY_EN : when defined, every frame carries one extra trailing
//                    parity bit, and the parity_err port is present.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   si         in   serial data bit
//   si_vld     in   si is sampled on this edge when high
//   clr        in   synchronous clear (wins over si_vld)
//   po         out  assembled parallel word (registered)
//   po_vld     out  po holds a word the consumer has not taken yet
//   po_rdy     in   consumer takes po when po_vld && po_rdy
//   busy       out  a frame is partially received
//   ovf        out  sticky overrun: a frame finished while po was still full
//   parity_err out  parity status of the word in po (SIPO_PARITY_EN only)

module sipo_deser #(
    parameter int WIDTH      = 4,
    parameter bit LSB_FIRST  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             si,
    input  logic             si_vld,
    input  logic             clr,
    output logic [WIDTH-1:0] po,
    output logic             po_vld,
    input  logic             po_rdy,
    output logic             busy,
    output logic             ovf
`ifdef SIPO_PARITY_EN
    ,
    output logic             parity_err
`endif
);

`ifdef SIPO_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    // Bits per frame and the counter that walks through them.
    localparam int              N     = WIDTH + PBITS;
    localparam int              CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] word;
    logic [0:0]       state;
    logic             take;
    logic             last_bit;
    logic             done;
    logic             free;
    logic             shift_en;

    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                  input logic             b);
        if (LSB_FIRST)
            shift_in = {b, s[WIDTH-1:1]};
        else
            shift_in = {s[WIDTH-2:0], b};
    endfunction

    // The state is fully described by the bit counter: IDLE at a frame
    // boundary, SHIFT while a frame is partially received.
    assign state = (cnt != '0) ? SHIFT : IDLE;
    assign busy  = (state == SHIFT);

    // clr outranks si_vld, so a clear edge never samples a bit.
    assign take     = si_vld & ~clr;
    assign last_bit = (cnt == LAST);
    assign done     = take & last_bit;
    // The holding register may be overwritten when empty, or when the
    // consumer empties it on this very edge.
    assign free     = ~po_vld | po_rdy;
    assign sreg_nxt = shift_in(sreg, si);

`ifdef SIPO_PARITY_EN
    // The trailing parity bit is checked but never shifted into the word,
    // so the data register already holds the full word on the last edge.
    logic perr_nxt;

    assign shift_en = take & ~last_bit;
    assign word     = sreg;
    assign perr_nxt = ((^sreg) ^ si) != PARITY_ODD;
`else
    assign shift_en = take;
    assign word     = sreg_nxt;

    // PARITY_ODD has no effect without the parity bit.
    if (PARITY_ODD) begin : g_parity_odd_unused
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            sreg   <= '0;
            po     <= '0;
            po_vld <= 1'b0;
            ovf    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (clr) begin
            // po is deliberately kept; only the control state is cleared.
            cnt    <= '0;
            sreg   <= '0;
            po_vld <= 1'b0;
            ovf    <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            if (take)
                cnt <= last_bit ? '0 : cnt + CNT_W'(1);
            if (shift_en)
                sreg <= sreg_nxt;

            if (done && free) begin
                po     <= word;
                po_vld <= 1'b1;
`ifdef SIPO_PARITY_EN
                parity_err <= perr_nxt;
`endif
            end else if (done) begin
                // Holding register still full: drop the new word.
                ovf <= 1'b1;
            end else if (po_vld && po_rdy) begin
                po_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sipo_deser.sv
// Directed testbench for sipo_deser. Two instances share all inputs: dut_m
// (MSB-first) and dut_l (LSB-first). Without SIPO_PARITY_EN the data-path,
// handshake, overrun, clear and reset scenarios run; with it the parity
// scenario runs instead.

module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rst;
    logic       si;
    logic       si_vld;
    logic       clr;
    logic       po_rdy;

    logic [3:0] po_m, po_l;
    logic       po_vld_m, po_vld_l;
    logic       busy_m, busy_l;
    logic       ovf_m, ovf_l;
`ifdef SIPO_PARITY_EN
    logic       perr_m, perr_l;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(4), .LSB_FIRST(1'b0), .PARITY_ODD(1'b0)) dut_m (
        .clk    (clk),
        .rst    (rst),
        .si     (si),
        .si_vld (si_vld),
        .clr    (clr),
        .po     (po_m),
        .po_vld (po_vld_m),
        .po_rdy (po_rdy),
        .busy   (busy_m),
        .ovf    (ovf_m)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err (perr_m)
`endif
    );

    sipo_deser #(.WIDTH(4), .LSB_FIRST(1'b1), .PARITY_ODD(1'b0)) dut_l (
        .clk    (clk),
        .rst    (rst),
        .si     (si),
        .si_vld (si_vld),
        .clr    (clr),
        .po     (po_l),
        .po_vld (po_vld_l),
        .po_rdy (po_rdy),
        .busy   (busy_l),
        .ovf    (ovf_l)
`ifdef SIPO_PARITY_EN
        ,
        .parity_err (perr_l)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        si     = b;
        si_vld = 1'b1;
        tick();
    endtask

    task automatic idle(input int n);
        si_vld = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst    = 1'b0;
        si     = 1'b0;
        si_vld = 1'b0;
        clr    = 1'b0;
        po_rdy = 1'b0;
        tick();
        tick();
        chk("reset_po",     po_m,     32'h0);
        chk("reset_po_vld", po_vld_m, 32'h0);
        chk("reset_busy",   busy_m,   32'h0);
        chk("reset_ovf",    ovf_m,    32'h0);
        rst = 1'b1;
        tick();

`ifndef SIPO_PARITY_EN
        // MSB-first frame 1,0,1,1 on consecutive edges.
        send_bit(1'b1); chk("msb_busy_e1", busy_m, 32'h1);
        send_bit(1'b0); chk("msb_busy_e2", busy_m, 32'h1);
        send_bit(1'b1); chk("msb_busy_e3", busy_m, 32'h1);
        chk("msb_no_vld_e3", po_vld_m, 32'h0);
        send_bit(1'b1);
        chk("msb_po_1011",  po_m,     32'hB);
        chk("msb_vld",      po_vld_m, 32'h1);
        chk("msb_busy_e4",  busy_m,   32'h0);
        chk("lsb_po_1101",  po_l,     32'hD);
        // Consume.
        si_vld = 1'b0;
        po_rdy = 1'b1;
        tick();
        po_rdy = 1'b0;
        chk("consume_vld0", po_vld_m, 32'h0);
        chk("consume_keep", po_m,     32'hB);

        // LSB-first frame 1,0,(3 idle),0,1.
        send_bit(1'b1);
        send_bit(1'b0);
        idle(3);
        chk("gap_busy",     busy_l,   32'h1);
        chk("gap_no_vld",   po_vld_l, 32'h0);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("lsb_po_1001",  po_l,     32'h9);
        chk("lsb_vld",      po_vld_l, 32'h1);
        si_vld = 1'b0;
        po_rdy = 1'b1;
        tick();
        po_rdy = 1'b0;

        // Overrun: two frames with no consumer.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
        chk("ovr_first_po", po_m,  32'hC);
        chk("ovr_first_ovf", ovf_m, 32'h0);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("ovr_po_kept",  po_m,     32'hC);
        chk("ovr_ovf",      ovf_m,    32'h1);
        chk("ovr_vld",      po_vld_m, 32'h1);
        si_vld = 1'b0;
        po_rdy = 1'b1;
        tick();
        po_rdy = 1'b0;
        chk("ovr_drain_vld", po_vld_m, 32'h0);
        chk("ovr_sticky",    ovf_m,    32'h1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ovf",      ovf_m, 32'h0);
        chk("clr_po_kept",  po_m,  32'hC);

        // Load-through: consumer takes old word on the completion edge.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("lt_first_po",  po_m, 32'hA);
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("lt_hold_vld",  po_vld_m, 32'h1);
        po_rdy = 1'b1;
        send_bit(1'b0);
        po_rdy = 1'b0;
        si_vld = 1'b0;
        chk("lt_po_0110",   po_m,     32'h6);
        chk("lt_vld",       po_vld_m, 32'h1);
        chk("lt_ovf",       ovf_m,    32'h0);

        // Asynchronous reset mid-frame after 2 of 4 bits.
        send_bit(1'b1);
        send_bit(1'b1);
        si_vld = 1'b0;
        chk("pre_rst_busy", busy_m, 32'h1);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_po",     po_m,     32'h0);
        chk("arst_vld",    po_vld_m, 32'h0);
        chk("arst_busy",   busy_m,   32'h0);
        chk("arst_ovf",    ovf_m,    32'h0);
        #2;
        rst = 1'b1;
        tick();
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        si_vld = 1'b0;
        chk("post_rst_po",  po_m,     32'h5);
        chk("post_rst_vld", po_vld_m, 32'h1);
`else
        // Data 1011 with correct even parity bit 1.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("par_busy_e4",  busy_m,   32'h1);
        chk("par_novld_e4", po_vld_m, 32'h0);
        send_bit(1'b1);
        chk("par_ok_po",    po_m,     32'hB);
        chk("par_ok_vld",   po_vld_m, 32'h1);
        chk("par_ok_err",   perr_m,   32'h0);
        si_vld = 1'b0;
        po_rdy = 1'b1;
        tick();
        po_rdy = 1'b0;
        // Data 1011 with wrong parity bit 0.
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0);
        si_vld = 1'b0;
        chk("par_bad_po",   po_m,     32'hB);
        chk("par_bad_vld",  po_vld_m, 32'h1);
        chk("par_bad_err",  perr_m,   32'h1);
        chk("par_bad_busy", busy_m,   32'h0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("par_clr_err",  perr_m,   32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
